// File: rtl/rom_boot_loader.sv
`default_nettype none
// ============================================================================
// Module : rom_boot_loader
// Brief  : Packs a byte-stream program image into 32-bit words, writes them to
//          the instruction ROM from address 0, then releases CPU reset.
// Rev    : 1.0  initial release
// ============================================================================
module rom_boot_loader #(
    parameter int ADDR_W      = 12,
    parameter int DEPTH       = 4096,
    parameter int RELEASE_DLY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              rom_we,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [31:0]       rom_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_cnt
);

    localparam logic [1:0] c_st_load  = 2'd0;
    localparam logic [1:0] c_st_write = 2'd1;
    localparam logic [1:0] c_st_done  = 2'd2;

    localparam int                 c_dly_w    = $clog2(RELEASE_DLY + 1);
    localparam logic [ADDR_W:0]    c_depth    = (ADDR_W + 1)'(DEPTH);
    localparam logic [c_dly_w-1:0] c_dly_init = c_dly_w'(RELEASE_DLY);
    localparam logic [c_dly_w-1:0] c_dly_one  = c_dly_w'(1);

    logic [1:0]         r_state;
    logic [1:0]         r_byte_idx;
    logic [31:0]        r_word;
    logic               r_last;
    logic [c_dly_w-1:0] r_dly;
    logic               r_in_ready;
    logic               r_rom_we;
    logic [ADDR_W-1:0]  r_rom_addr;
    logic [31:0]        r_rom_wdata;
    logic               r_cpu_rst_n;
    logic               r_busy;
    logic               r_done;
    logic               r_overflow;
    logic [ADDR_W:0]    r_word_cnt;

    logic               w_accept;
    logic               w_word_end;
    logic [31:0]        w_packed;
    logic [1:0]         w_state_nxt;

    assign w_accept   = in_valid & r_in_ready;
    assign w_word_end = w_accept & ((r_byte_idx == 2'd3) | in_last);

    // Upper bytes of r_word are always zero here, so a short word pads itself.
    always_comb begin
        w_packed = r_word;
        w_packed[{r_byte_idx, 3'b000} +: 8] = in_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_load:  if (w_word_end) w_state_nxt = c_st_write;
            c_st_write: w_state_nxt = r_last ? c_st_done : c_st_load;
            c_st_done:  if (start) w_state_nxt = c_st_load;
            default:    w_state_nxt = c_st_load;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_load;
            r_byte_idx  <= 2'd0;
            r_word      <= 32'd0;
            r_last      <= 1'b0;
            r_dly       <= '0;
            r_in_ready  <= 1'b1;
            r_rom_we    <= 1'b0;
            r_rom_addr  <= '0;
            r_rom_wdata <= 32'd0;
            r_cpu_rst_n <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt == c_st_load);
            r_busy     <= (w_state_nxt != c_st_done);
            r_done     <= (w_state_nxt == c_st_done);
            r_rom_we   <= 1'b0;
            case (r_state)
                c_st_load: begin
                    if (w_accept) begin
                        r_word     <= w_packed;
                        r_byte_idx <= r_byte_idx + 2'd1;
                    end
                    // Write port is loaded one cycle early so the strobe is a flop.
                    if (w_word_end) begin
                        r_last      <= in_last;
                        r_rom_we    <= (r_word_cnt != c_depth);
                        r_rom_addr  <= r_word_cnt[ADDR_W-1:0];
                        r_rom_wdata <= w_packed;
                    end
                end
                c_st_write: begin
                    r_word     <= 32'd0;
                    r_byte_idx <= 2'd0;
                    r_dly      <= c_dly_init;
                    if (r_word_cnt == c_depth) begin
                        r_overflow <= 1'b1;
                    end else begin
                        r_word_cnt <= r_word_cnt + (ADDR_W + 1)'(1);
                    end
                end
                c_st_done: begin
                    if (start) begin
                        r_overflow  <= 1'b0;
                        r_word_cnt  <= '0;
                        r_byte_idx  <= 2'd0;
                        r_word      <= 32'd0;
                        r_last      <= 1'b0;
                        r_cpu_rst_n <= 1'b0;
                    end else if (r_dly != '0) begin
                        r_dly <= r_dly - c_dly_one;
                        if (r_dly == c_dly_one) r_cpu_rst_n <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign rom_we    = r_rom_we;
    assign rom_addr  = r_rom_addr;
    assign rom_wdata = r_rom_wdata;
    assign cpu_rst_n = r_cpu_rst_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_overflow;
    assign word_cnt  = r_word_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rom_boot_loader.sv
`default_nettype none
// ============================================================================
// Module : tb_rom_boot_loader
// Brief  : Self-checking bench for rom_boot_loader (DEPTH=4 to reach overflow).
// Rev    : 1.0  initial release
// ============================================================================
module tb_rom_boot_loader;

    localparam int ADDR_W      = 12;
    localparam int DEPTH       = 4;
    localparam int RELEASE_DLY = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              rom_we;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_wdata;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              overflow;
    logic [ADDR_W:0]   word_cnt;

    int total = 0;
    int bad   = 0;

    logic [7:0]  img[$];
    wr_t         exp_q[$];
    logic [31:0] ref_rom[DEPTH];
    logic [31:0] dut_rom[DEPTH];

    always #5 clk = ~clk;

    rom_boot_loader #(
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .RELEASE_DLY (RELEASE_DLY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .rom_we    (rom_we),
        .rom_addr  (rom_addr),
        .rom_wdata (rom_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .word_cnt  (word_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word w of the image: little-endian bytes 4w..4w+3, missing bytes are zero.
    function automatic logic [31:0] pack_word(input int w);
        logic [31:0] r = 32'd0;
        for (int b = 0; b < 4; b++)
            if (4 * w + b < img.size()) r[8 * b +: 8] = img[4 * w + b];
        return r;
    endfunction

    task automatic expect_writes(input int nbytes, input bit partial);
        int  nw;
        wr_t e;
        nw = partial ? nbytes / 4 : (nbytes + 3) / 4;
        for (int w = 0; w < nw; w++) begin
            if (w < DEPTH) begin
                e.a = ADDR_W'(w);
                e.d = pack_word(w);
                exp_q.push_back(e);
                ref_rom[w] = e.d;
            end
        end
    endtask

    task automatic set_img(input logic [63:0] v, input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(v[8 * i +: 8]);
    endtask

    // Cycle-level reference: ready/busy/done/release and write strobe predicted
    // from the accepted byte stream alone.
    bit chk_en  = 1'b0;
    bit m_wcyc  = 1'b0;
    bit m_wovf  = 1'b0;
    bit m_wlast = 1'b0;
    bit m_done  = 1'b0;
    int m_dn    = 0;
    int m_bytes = 0;
    int m_words = 0;

    always @(negedge clk) begin
        bit  n_wcyc;
        bit  n_wovf;
        bit  n_wlast;
        wr_t e;
        if (chk_en) begin
            chk("rom_we", rom_we, m_wcyc && !m_wovf);
            if (rom_we) begin
                chk("write_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("rom_addr", rom_addr, e.a);
                    chk("rom_wdata", rom_wdata, e.d);
                end
                if (rom_addr < DEPTH) dut_rom[rom_addr] = rom_wdata;
            end
            chk("in_ready", in_ready, !m_done && !m_wcyc);
            chk("busy", busy, !m_done);
            chk("done", done, m_done);
            chk("cpu_rst_n", cpu_rst_n, m_done && (m_dn >= RELEASE_DLY));
        end
        n_wcyc  = 1'b0;
        n_wovf  = 1'b0;
        n_wlast = 1'b0;
        if (rst) begin
            m_done  = 1'b0;
            m_dn    = 0;
            m_bytes = 0;
            m_words = 0;
        end else begin
            if (m_done) begin
                if (start) begin
                    m_done  = 1'b0;
                    m_dn    = 0;
                    m_bytes = 0;
                    m_words = 0;
                end else begin
                    m_dn++;
                end
            end else if (m_wcyc && m_wlast) begin
                m_done = 1'b1;
                m_dn   = 0;
            end
            if (in_valid && in_ready) begin
                m_bytes++;
                if ((m_bytes % 4 == 0) || in_last) begin
                    n_wcyc  = 1'b1;
                    n_wovf  = (m_words >= DEPTH);
                    n_wlast = in_last;
                    m_words++;
                end
            end
        end
        m_wcyc  = n_wcyc;
        m_wovf  = n_wovf;
        m_wlast = n_wlast;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic stream(input int n, input bit use_last, input bit gaps, input bit mid_start);
        for (int i = 0; i < n; i++) begin
            int g;
            if (gaps) begin
                int k = 0;
                while ($urandom_range(0, 1) == 1 && k < 4) begin
                    in_valid = 1'b0;
                    start    = 1'b0;
                    tick();
                    k++;
                end
            end
            in_valid = 1'b1;
            in_data  = img[i];
            in_last  = use_last && (i == n - 1);
            start    = mid_start && (i == 2);
            g = 0;
            forever begin
                @(negedge clk);
                if (in_ready || g > 50) break;
                g++;
            end
            if (!in_ready) chk("byte_accept_timeout", in_ready, 1'b1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        start    = 1'b0;
    endtask

    task automatic finish_load(input int exp_wc, input bit exp_ovf);
        int k;
        k = 0;
        @(negedge clk);
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("done_seen", done, 1'b1);
        k = 0;
        while (!cpu_rst_n && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("release_delay", k, RELEASE_DLY);
        chk("word_cnt", word_cnt, exp_wc);
        chk("overflow", overflow, exp_ovf);
        chk("writes_outstanding", exp_q.size(), 0);
        tick();
    endtask

    task automatic start_pulse;
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        chk("start_cpu_rst_n", cpu_rst_n, 1'b0);
        chk("start_done", done, 1'b0);
        chk("start_overflow", overflow, 1'b0);
        chk("start_word_cnt", word_cnt, 0);
        chk("start_in_ready", in_ready, 1'b1);
        tick();
    endtask

    task automatic check_reset_values;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_busy", busy, 1'b1);
        chk("rst_done", done, 1'b0);
        chk("rst_cpu_rst_n", cpu_rst_n, 1'b0);
        chk("rst_rom_we", rom_we, 1'b0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_rom_wdata", rom_wdata, 32'd0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_word_cnt", word_cnt, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lens[3];
        lens = '{9, 13, 16};

        repeat (2) tick();
        @(negedge clk);
        check_reset_values();
        tick();
        rst    = 1'b0;
        chk_en = 1'b1;

        // Two-word image straight out of reset
        set_img(64'h00100093_00000013, 8);
        expect_writes(8, 1'b0);
        stream(8, 1'b1, 1'b0, 1'b0);
        finish_load(2, 1'b0);
        chk("t1_addr0", dut_rom[0], 32'h00000013);
        chk("t1_addr1", dut_rom[1], 32'h00100093);

        // Short final word padded with zeros
        start_pulse();
        set_img(64'h2211DDCCBBAA, 6);
        expect_writes(6, 1'b0);
        stream(6, 1'b1, 1'b0, 1'b0);
        finish_load(2, 1'b0);
        chk("t2_addr0", dut_rom[0], 32'hDDCCBBAA);
        chk("t2_addr1", dut_rom[1], 32'h00002211);

        // 20 bytes into a 4-word ROM
        start_pulse();
        img.delete();
        for (int i = 0; i < 20; i++) img.push_back(8'(i + 1));
        expect_writes(20, 1'b0);
        stream(20, 1'b1, 1'b0, 1'b0);
        finish_load(4, 1'b1);
        chk("t3_addr3", dut_rom[3], 32'h100F0E0D);

        // Reload after DONE, with a stray start mid-load
        start_pulse();
        set_img(64'hDEADBEEF, 4);
        expect_writes(4, 1'b0);
        stream(4, 1'b1, 1'b0, 1'b1);
        finish_load(1, 1'b0);
        chk("t6_addr0", dut_rom[0], 32'hDEADBEEF);

        // Random data with random valid gaps
        for (int r = 0; r < 3; r++) begin
            start_pulse();
            img.delete();
            for (int i = 0; i < lens[r]; i++) img.push_back(8'($urandom));
            for (int w = 0; w < DEPTH; w++) dut_rom[w] = 32'hx;
            expect_writes(lens[r], 1'b0);
            stream(lens[r], 1'b1, 1'b1, 1'b0);
            finish_load((lens[r] + 3) / 4, 1'b0);
            for (int w = 0; w < (lens[r] + 3) / 4; w++)
                chk("t4_rom_content", dut_rom[w], ref_rom[w]);
        end

        // Reset in the middle of a load, then a fresh image
        start_pulse();
        set_img(64'h161514131211, 6);
        expect_writes(6, 1'b1);
        stream(6, 1'b0, 1'b0, 1'b0);
        repeat (2) tick();
        chk("t5_cpu_held", cpu_rst_n, 1'b0);
        chk("t5_partial_writes", exp_q.size(), 0);
        chk("t5_partial_addr0", dut_rom[0], 32'h14131211);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check_reset_values();
        tick();
        set_img(64'h04030201, 4);
        expect_writes(4, 1'b0);
        stream(4, 1'b1, 1'b0, 1'b0);
        finish_load(1, 1'b0);
        chk("t5_addr0", dut_rom[0], 32'h04030201);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
